// File: rtl/fb_write_arbiter_if.sv
// Write-side bus of the framebuffer arbiter: CPU write handshake, clear
// control/status and the merged registered framebuffer write port.
interface fb_wr_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 8
);
    logic              cpu_valid;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_data;
    logic              cpu_ready;
    logic              clear_start;
    logic [DATA_W-1:0] clear_value;
    logic              clear_busy;
    logic              clear_done;
    logic [ADDR_W-1:0] fb_addr;
    logic [DATA_W-1:0] fb_data;
    logic              fb_we;

    modport slave (
        input  cpu_valid, cpu_addr, cpu_data, clear_start, clear_value,
        output cpu_ready, clear_busy, clear_done, fb_addr, fb_data, fb_we
    );

    modport master (
        output cpu_valid, cpu_addr, cpu_data, clear_start, clear_value,
        input  cpu_ready, clear_busy, clear_done, fb_addr, fb_data, fb_we
    );
endinterface

// File: rtl/fb_write_arbiter.sv
// Merges a 2-deep CPU write FIFO and a framebuffer clear sweep onto one
// registered write port. Define FB_CLEAR_EN to build the clear engine.
module fb_write_arbiter #(
    parameter int ADDR_W   = 12,
    parameter int DATA_W   = 8,
    parameter int FB_DEPTH = 4096
) (
    input  logic   clk,
    input  logic   rst,
    fb_wr_if.slave bus
);
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_t;

    wr_t        fifo_q [2];
    wr_t        fifo_d [2];
    logic       wr_ptr_q, wr_ptr_d;
    logic       rd_ptr_q, rd_ptr_d;
    logic [1:0] cnt_q, cnt_d;
    wr_t        out_q, out_d;
    logic       we_q, we_d;
    logic       push, pop, cpu_pend;
    logic       gnt_cpu, gnt_clr;
    wr_t        clr_wr;

    // Ready looks only at registered occupancy, so a full FIFO stalls the CPU
    // for a cycle even when the head is being drained.
    assign bus.cpu_ready = ~rst & (cnt_q != 2'd2);
    assign push          = bus.cpu_valid & bus.cpu_ready;
    assign pop           = gnt_cpu;
    assign cpu_pend      = (cnt_q != 2'd0);

    always_comb begin
        fifo_d   = fifo_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push) begin
            fifo_d[wr_ptr_q] = '{addr: bus.cpu_addr, data: bus.cpu_data};
            wr_ptr_d         = ~wr_ptr_q;
        end
        if (pop) rd_ptr_d = ~rd_ptr_q;
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + 2'd1;
            2'b01:   cnt_d = cnt_q - 2'd1;
            default: cnt_d = cnt_q;
        endcase
    end

`ifdef FB_CLEAR_EN
    localparam logic [0:0]        IDLE      = 1'b0;
    localparam logic [0:0]        SWEEP     = 1'b1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FB_DEPTH - 1);

    logic [0:0]        state_q, state_d;
    logic [ADDR_W-1:0] caddr_q, caddr_d;
    logic [DATA_W-1:0] cval_q, cval_d;
    logic              last_clr_q, last_clr_d;
    logic              done_q, done_d;
    logic              clr_pend;

    // Round robin: when both sources are pending, the one not served last wins.
    assign clr_pend = (state_q == SWEEP);
    assign gnt_cpu  = cpu_pend & (~clr_pend | last_clr_q);
    assign gnt_clr  = clr_pend & (~cpu_pend | ~last_clr_q);
    assign clr_wr   = '{addr: caddr_q, data: cval_q};

    always_comb begin
        state_d    = state_q;
        caddr_d    = caddr_q;
        cval_d     = cval_q;
        last_clr_d = last_clr_q;
        done_d     = 1'b0;
        if (gnt_cpu) last_clr_d = 1'b0;
        if (gnt_clr) last_clr_d = 1'b1;
        case (state_q)
            IDLE: begin
                if (bus.clear_start) begin
                    state_d = SWEEP;
                    caddr_d = '0;
                    cval_d  = bus.clear_value;
                end
            end
            default: begin
                if (gnt_clr) begin
                    caddr_d = caddr_q + ADDR_W'(1);
                    if (caddr_q == LAST_ADDR) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            caddr_q    <= '0;
            cval_q     <= '0;
            last_clr_q <= 1'b1;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            caddr_q    <= caddr_d;
            cval_q     <= cval_d;
            last_clr_q <= last_clr_d;
            done_q     <= done_d;
        end
    end

    // done_q lines up with the final write on fb_*, so busy covers that cycle too.
    assign bus.clear_busy = clr_pend | done_q;
    assign bus.clear_done = done_q;
`else
    logic unused_clear;

    assign gnt_cpu        = cpu_pend;
    assign gnt_clr        = 1'b0;
    assign clr_wr         = '0;
    assign bus.clear_busy = 1'b0;
    assign bus.clear_done = 1'b0;
    assign unused_clear   = ^{bus.clear_start, bus.clear_value} ^ (FB_DEPTH > 0);
`endif

    always_comb begin
        we_d  = gnt_cpu | gnt_clr;
        out_d = out_q;
        if (gnt_cpu)      out_d = fifo_q[rd_ptr_q];
        else if (gnt_clr) out_d = clr_wr;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fifo_q[0] <= '0;
            fifo_q[1] <= '0;
            wr_ptr_q  <= 1'b0;
            rd_ptr_q  <= 1'b0;
            cnt_q     <= 2'd0;
            out_q     <= '0;
            we_q      <= 1'b0;
        end else begin
            fifo_q    <= fifo_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            cnt_q     <= cnt_d;
            out_q     <= out_d;
            we_q      <= we_d;
        end
    end

    assign bus.fb_addr = out_q.addr;
    assign bus.fb_data = out_q.data;
    assign bus.fb_we   = we_q;
endmodule

// File: tb/tb_fb_write_arbiter.sv
// Self-checking bench for fb_write_arbiter; clear scenarios run when FB_CLEAR_EN is defined.
`timescale 1ns/1ps
module tb_fb_write_arbiter;
    localparam int AW = 12, DW = 8, DEPTH = 16;

    typedef struct { logic [AW-1:0] addr; logic [DW-1:0] data; logic done; } exp_t;
    typedef struct { logic [AW-1:0] addr; logic [DW-1:0] data; } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fb_wr_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
    fb_write_arbiter #(.ADDR_W(AW), .DATA_W(DW), .FB_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    int   n_chk = 0, n_fail = 0;
    int   we_cnt = 0, done_cnt = 0;
    exp_t cpu_q[$], clr_q[$];
    bit   src_hist[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard: clear writes live below DEPTH, CPU writes are kept above it.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (bus.clear_done === 1'b1) done_cnt++;
        if (bus.fb_we === 1'b1) begin
            we_cnt++;
            if (bus.fb_addr < AW'(DEPTH)) begin
                src_hist.push_back(1'b1);
                if (clr_q.size() == 0) check("clr_extra_write", 32'(clr_q.size()), 1);
                else begin
                    e = clr_q.pop_front();
                    check("clr_write", {bus.fb_addr, bus.fb_data, bus.clear_done}, {e.addr, e.data, e.done});
                end
            end else begin
                src_hist.push_back(1'b0);
                if (cpu_q.size() == 0) check("cpu_extra_write", 32'(cpu_q.size()), 1);
                else begin
                    e = cpu_q.pop_front();
                    check("cpu_write", {bus.fb_addr, bus.fb_data, bus.clear_done}, {e.addr, e.data, e.done});
                end
            end
        end else if (bus.clear_done === 1'b1) begin
            check("done_without_write", 32'(bus.clear_done), 0);
        end
    end

    task automatic do_reset();
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
    endtask

    vec_t       vecs[4];
    logic [7:0] pat;
    logic [6:0] hist;
    int         k, base, dbase;
    bit         dropped, seen, busy_seen;

    initial begin
        vecs[0] = '{addr: 12'h123, data: 8'hA5};
        vecs[1] = '{addr: 12'hFFF, data: 8'h00};
        vecs[2] = '{addr: 12'h010, data: 8'hFF};
        vecs[3] = '{addr: 12'h800, data: 8'h3C};

        bus.cpu_valid = 1'b0; bus.cpu_addr = '0; bus.cpu_data = '0;
        bus.clear_start = 1'b0; bus.clear_value = '0;

        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_cpu_ready", bus.cpu_ready, 0);
        check("rst_busy", bus.clear_busy, 0);
        check("rst_done", bus.clear_done, 0);
        check("rst_we", bus.fb_we, 0);
        check("rst_addr", bus.fb_addr, 0);
        check("rst_data", bus.fb_data, 0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("ready_after_rst", bus.cpu_ready, 1);

        // Single CPU writes: accept in N, fb_we in N+2 only, value held after
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            bus.cpu_valid = 1'b1; bus.cpu_addr = vecs[i].addr; bus.cpu_data = vecs[i].data;
            @(negedge clk);
            check("acc_ready", bus.cpu_ready, 1);
            cpu_q.push_back('{addr: vecs[i].addr, data: vecs[i].data, done: 1'b0});
            @(posedge clk); #1 bus.cpu_valid = 1'b0;
            @(negedge clk);
            check("lat_n1_we", bus.fb_we, 0);
            @(negedge clk);
            check("lat_n2_we", bus.fb_we, 1);
            check("lat_n2_wr", {bus.fb_addr, bus.fb_data}, {vecs[i].addr, vecs[i].data});
            @(negedge clk);
            check("we_one_cycle", bus.fb_we, 0);
            check("hold_wr", {bus.fb_addr, bus.fb_data}, {vecs[i].addr, vecs[i].data});
        end

        // Four back-to-back writes: ready stays high, fb_we 4 consecutive cycles
        pat = '0;
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) begin
            bus.cpu_valid = 1'b1; bus.cpu_addr = 12'h200 + 12'(i); bus.cpu_data = 8'h40 + 8'(i);
            @(negedge clk);
            check("b2b_ready", bus.cpu_ready, 1);
            pat = {pat[6:0], bus.fb_we};
            cpu_q.push_back('{addr: 12'h200 + 12'(i), data: 8'h40 + 8'(i), done: 1'b0});
            @(posedge clk); #1;
        end
        bus.cpu_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            pat = {pat[6:0], bus.fb_we};
        end
        check("b2b_we_pattern", pat, 8'b0011_1100);

`ifdef FB_CLEAR_EN
        // Plain clear sweep, with an ignored clear_start mid-sweep
        @(posedge clk); #1;
        bus.clear_start = 1'b1; bus.clear_value = 8'h20;
        for (int a = 0; a < DEPTH; a++)
            clr_q.push_back('{addr: AW'(a), data: 8'h20, done: (a == DEPTH - 1)});
        @(negedge clk);
        check("busy_start_cycle", bus.clear_busy, 0);
        @(posedge clk); #1 bus.clear_start = 1'b0;
        @(negedge clk);
        check("busy_first", bus.clear_busy, 1);
        check("sweep_we_first", bus.fb_we, 0);
        for (int i = 0; i < DEPTH; i++) begin
            @(posedge clk); #1;
            bus.clear_start = (i == 3); bus.clear_value = 8'h77;
            @(negedge clk);
            check("sweep_we", bus.fb_we, 1);
            if (i == DEPTH - 1) begin
                check("sweep_done", bus.clear_done, 1);
                check("sweep_busy_last", bus.clear_busy, 1);
            end
        end
        bus.clear_start = 1'b0;
        @(negedge clk);
        check("busy_after", bus.clear_busy, 0);
        check("done_after", bus.clear_done, 0);
        check("we_after", bus.fb_we, 0);
        check("clr_q_drained", 32'(clr_q.size()), 0);

        // Clear plus 3 CPU writes straight after reset: CPU first, then alternate
        do_reset();
        src_hist.delete();
        k = 0; dropped = 1'b0;
        for (int a = 0; a < DEPTH; a++)
            clr_q.push_back('{addr: AW'(a), data: 8'h20, done: (a == DEPTH - 1)});
        bus.clear_start = 1'b1; bus.clear_value = 8'h20;
        bus.cpu_valid = 1'b1; bus.cpu_addr = 12'h300; bus.cpu_data = 8'h90;
        for (int c = 0; c < 24; c++) begin
            @(negedge clk);
            if (!bus.cpu_ready) dropped = 1'b1;
            if (bus.cpu_valid && bus.cpu_ready) begin
                cpu_q.push_back('{addr: bus.cpu_addr, data: bus.cpu_data, done: 1'b0});
                k++;
            end
            @(posedge clk); #1;
            bus.clear_start = 1'b0;
            bus.cpu_valid = (k < 3); bus.cpu_addr = 12'h300 + 12'(k); bus.cpu_data = 8'h90 + 8'(k);
        end
        bus.cpu_valid = 1'b0;
        check("mix_ready_dropped", dropped, 1);
        check("mix_hist_len", 32'(src_hist.size()), 19);
        if (src_hist.size() >= 7) begin
            hist = '0;
            for (int i = 0; i < 7; i++) hist = {hist[5:0], src_hist[i]};
            check("mix_grant_order", hist, 7'b0101011);
        end
        check("mix_clr_q_drained", 32'(clr_q.size()), 0);
        check("mix_cpu_q_drained", 32'(cpu_q.size()), 0);

        // Reset at clear address 5 aborts the sweep; a new clear restarts at 0
        @(posedge clk); #1;
        bus.clear_start = 1'b1; bus.clear_value = 8'h20;
        for (int a = 0; a < 6; a++) clr_q.push_back('{addr: AW'(a), data: 8'h20, done: 1'b0});
        @(posedge clk); #1 bus.clear_start = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 30 && !seen; c++) begin
            @(negedge clk);
            if (bus.fb_we === 1'b1 && bus.fb_addr == 12'd5) seen = 1'b1;
        end
        check("abort_saw_addr5", seen, 1);
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        base = we_cnt; dbase = done_cnt;
        repeat (20) @(negedge clk);
        check("abort_no_writes", 32'(we_cnt - base), 0);
        check("abort_no_done", 32'(done_cnt - dbase), 0);
        check("abort_busy", bus.clear_busy, 0);
        @(posedge clk); #1;
        bus.clear_start = 1'b1; bus.clear_value = 8'h20;
        for (int a = 0; a < DEPTH; a++)
            clr_q.push_back('{addr: AW'(a), data: 8'h20, done: (a == DEPTH - 1)});
        @(posedge clk); #1 bus.clear_start = 1'b0;
        repeat (22) @(negedge clk);
        check("restart_writes", 32'(we_cnt - base), DEPTH);
        check("restart_done", 32'(done_cnt - dbase), 1);
`else
        // Without the clear engine a clear_start pulse does nothing
        base = we_cnt; busy_seen = 1'b0;
        @(posedge clk); #1;
        bus.clear_start = 1'b1; bus.clear_value = 8'h20;
        @(posedge clk); #1 bus.clear_start = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (bus.clear_busy !== 1'b0 || bus.clear_done !== 1'b0) busy_seen = 1'b1;
        end
        check("noclr_no_write", 32'(we_cnt - base), 0);
        check("noclr_busy_done", busy_seen, 0);
`endif

        check("cpu_q_drained", 32'(cpu_q.size()), 0);
        check("clr_q_empty", 32'(clr_q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
